// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART MMIO responder: register offsets,
// status-word bit positions and the address decoder.
package uart_mmio_pkg;

  localparam logic [31:0] OFS_TXSPACE = 32'h0000_0000;
  localparam logic [31:0] OFS_RXAVAIL = 32'h0000_0004;
  localparam logic [31:0] OFS_TXDATA  = 32'h0000_0008;
  localparam logic [31:0] OFS_RXDATA  = 32'h0000_000C;
  localparam logic [31:0] OFS_STATUS  = 32'h0000_0010;

  localparam int ST_TX_DROP   = 15;
  localparam int ST_RX_DROP   = 14;
  localparam int ST_TXCNT_LSB = 4;
  localparam int ST_RXCNT_LSB = 0;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TXSPACE,
    REG_RXAVAIL,
    REG_TXDATA,
    REG_RXDATA,
    REG_STATUS
  } reg_sel_e;

  // Exact full-width compare; anything else in the window is unmapped.
  function automatic reg_sel_e decode_addr(input logic [31:0] addr,
                                           input logic [31:0] base);
    reg_sel_e sel;
    sel = REG_NONE;
    if (addr == base + OFS_TXSPACE) sel = REG_TXSPACE;
    if (addr == base + OFS_RXAVAIL) sel = REG_RXAVAIL;
    if (addr == base + OFS_TXDATA)  sel = REG_TXDATA;
    if (addr == base + OFS_RXDATA)  sel = REG_RXDATA;
    if (addr == base + OFS_STATUS)  sel = REG_STATUS;
    return sel;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular-buffer FIFO with a separate occupancy counter. A push while full
// is accepted when a pop happens in the same cycle.
module byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head is forced to zero when empty so reset and empty reads both show 0.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_mmio_responder.sv
// CPU-facing UART register window: address decode, registered read data,
// sticky overflow flags, and one byte_fifo each for TX and RX.
module uart_mmio_responder
  import uart_mmio_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'h8000_0000,
  parameter int          DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic        req_re,
  input  logic [7:0]  req_wdata,
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  function automatic logic [3:0] count_nibble(input logic [CW-1:0] c);
    return 4'(c);
  endfunction

  reg_sel_e        sel;
  logic            rd_en;
  logic            tx_push;
  logic            tx_pop;
  logic            tx_full;
  logic            tx_empty;
  logic [CW-1:0]   tx_count;
  logic            rx_pop;
  logic            rx_full;
  logic            rx_empty;
  logic [CW-1:0]   rx_count;
  logic [7:0]      rx_head;
  logic            tx_drop;
  logic            rx_drop;
  logic            tx_drop_ev;
  logic            rx_drop_ev;
  logic            status_clr;
  logic [31:0]     status_word;
  logic [31:0]     rd_value;

  assign sel        = decode_addr(req_addr, BASE);
  // A simultaneous store wins; the load is dropped and rdata holds.
  assign rd_en      = req_re && !req_we;
  assign tx_push    = req_we && (sel == REG_TXDATA);
  assign tx_valid   = !tx_empty;
  assign tx_pop     = tx_valid && tx_ready;
  assign rx_pop     = rd_en && (sel == REG_RXDATA);
  assign rx_ready   = 1'b1;
  assign status_clr = rd_en && (sel == REG_STATUS);

  assign tx_drop_ev = tx_push && tx_full && !tx_pop;
  assign rx_drop_ev = rx_valid && rx_full && !rx_pop;

  byte_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_push),
    .pop     (tx_pop),
    .din     (req_wdata),
    .dout    (tx_data),
    .count   (tx_count),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  byte_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rx_valid),
    .pop     (rx_pop),
    .din     (rx_data),
    .dout    (rx_head),
    .count   (rx_count),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  always_comb begin
    status_word = '0;
    status_word[ST_TX_DROP] = tx_drop;
    status_word[ST_RX_DROP] = rx_drop;
    status_word[ST_TXCNT_LSB +: 4] = count_nibble(tx_count);
    status_word[ST_RXCNT_LSB +: 4] = count_nibble(rx_count);
  end

  // Read mux sees pre-update FIFO state and pre-clear flags.
  always_comb begin
    rd_value = '0;
    unique case (sel)
      REG_TXSPACE: rd_value = {31'b0, !tx_full};
      REG_RXAVAIL: rd_value = {31'b0, !rx_empty};
      REG_RXDATA:  rd_value = {24'b0, rx_head};
      REG_STATUS:  rd_value = status_word;
      default:     rd_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_value;
    end
  end

  // A drop in the same cycle as the clearing read keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_drop <= 1'b0;
      rx_drop <= 1'b0;
    end else begin
      if (tx_drop_ev)      tx_drop <= 1'b1;
      else if (status_clr) tx_drop <= 1'b0;
      if (rx_drop_ev)      rx_drop <= 1'b1;
      else if (status_clr) rx_drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_mmio_responder.sv
// Directed bench for uart_mmio_responder with a queue-based reference model
// checked every cycle, plus literal expectations on each register read.
module tb_uart_mmio_responder;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 8;

  logic        clk;
  logic        reset_n;
  logic [31:0] req_addr;
  logic        req_we;
  logic        req_re;
  logic [7:0]  req_wdata;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  uart_mmio_responder #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_re    (req_re),
    .req_wdata (req_wdata),
    .rdata     (rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues and flags.
  logic [7:0]  txq[$];
  logic [7:0]  rxq[$];
  bit          m_tx_drop;
  bit          m_rx_drop;
  logic [31:0] m_rdata;

  task automatic model_step();
    int txn;
    int rxn;
    bit rd;
    bit txpop;
    bit rxpop;
    bit tx_ev;
    bit rx_ev;
    logic [31:0] off;
    logic [31:0] v;
    if (!reset_n) begin
      txq.delete();
      rxq.delete();
      m_tx_drop = 0;
      m_rx_drop = 0;
      m_rdata   = 0;
      return;
    end
    txn   = txq.size();
    rxn   = rxq.size();
    rd    = req_re && !req_we;
    off   = req_addr - BASE;
    txpop = (txn > 0) && tx_ready;
    rxpop = rd && (off == 32'hC) && (rxn > 0);
    v = 0;
    case (off)
      32'h0:  v = (txn < DEPTH) ? 1 : 0;
      32'h4:  v = (rxn != 0) ? 1 : 0;
      32'hC:  v = (rxn != 0) ? {24'b0, rxq[0]} : 0;
      32'h10: v = (32'(m_tx_drop) << 15) | (32'(m_rx_drop) << 14)
                  | (32'(txn) << 4) | 32'(rxn);
      default: v = 0;
    endcase
    tx_ev = 0;
    rx_ev = 0;
    if (txpop) void'(txq.pop_front());
    if (req_we && off == 32'h8) begin
      if (txn < DEPTH || txpop) txq.push_back(req_wdata);
      else tx_ev = 1;
    end
    if (rxpop) void'(rxq.pop_front());
    if (rx_valid) begin
      if (rxn < DEPTH || rxpop) rxq.push_back(rx_data);
      else rx_ev = 1;
    end
    if (rd && off == 32'h10) begin
      m_tx_drop = tx_ev;
      m_rx_drop = rx_ev;
    end else begin
      m_tx_drop = m_tx_drop | tx_ev;
      m_rx_drop = m_rx_drop | rx_ev;
    end
    if (rd) m_rdata = v;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        check("m_tx_valid", {31'b0, tx_valid}, (txq.size() != 0) ? 1 : 0);
        if (txq.size() != 0) check("m_tx_data", {24'b0, tx_data}, {24'b0, txq[0]});
        check("m_rdata", rdata, m_rdata);
        check("m_rx_ready", {31'b0, rx_ready}, 1);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] ofs, input logic [7:0] d);
    req_addr  = BASE + ofs;
    req_wdata = d;
    req_we    = 1;
    cyc();
    req_we    = 0;
  endtask

  task automatic rd(input string name, input logic [31:0] ofs, input logic [31:0] exp);
    req_addr = BASE + ofs;
    req_re   = 1;
    cyc();
    req_re   = 0;
    check(name, rdata, exp);
  endtask

  task automatic rx_push(input logic [7:0] d);
    rx_data  = d;
    rx_valid = 1;
    cyc();
    rx_valid = 0;
  endtask

  initial begin
    reset_n   = 0;
    req_addr  = 0;
    req_we    = 0;
    req_re    = 0;
    req_wdata = 0;
    tx_ready  = 0;
    rx_data   = 0;
    rx_valid  = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 0);
    check("rst_tx_valid", {31'b0, tx_valid}, 0);
    check("rst_tx_data", {24'b0, tx_data}, 0);
    check("rst_rx_ready", {31'b0, rx_ready}, 1);
    reset_n = 1;
    cyc();

    rd("txspace_empty", 32'h0, 1);
    rd("rxavail_empty", 32'h4, 0);
    check("tx_valid_idle", {31'b0, tx_valid}, 0);

    wr(32'h8, 8'h41);
    wr(32'h8, 8'h42);
    check("tx_valid_after_store", {31'b0, tx_valid}, 1);
    check("tx_head_41", {24'b0, tx_data}, 32'h41);
    tx_ready = 1;
    cyc();
    tx_ready = 0;
    check("tx_head_42", {24'b0, tx_data}, 32'h42);
    tx_ready = 1;
    cyc();
    tx_ready = 0;
    check("tx_drained", {31'b0, tx_valid}, 0);

    for (int i = 0; i < 9; i++) wr(32'h8, 8'(i + 1));
    check("tx_head_fill", {24'b0, tx_data}, 32'h01);
    rd("txspace_full", 32'h0, 0);
    rd("status_txdrop", 32'h10, 32'h0000_8080);
    rd("status_cleared", 32'h10, 32'h0000_0080);
    tx_ready = 1;
    repeat (8) cyc();
    tx_ready = 0;
    check("tx_drained_full", {31'b0, tx_valid}, 0);

    rx_push(8'h55);
    rx_push(8'hAA);
    rd("rxavail_2", 32'h4, 1);
    rd("rx_55", 32'hC, 32'h55);
    rd("rx_AA", 32'hC, 32'hAA);
    rd("rx_empty_read", 32'hC, 0);
    rd("rxavail_0", 32'h4, 0);

    for (int i = 0; i < 8; i++) rx_push(8'(8'h10 + i));
    rd("status_rxfull", 32'h10, 32'h0000_0008);
    rx_data  = 8'h99;
    rx_valid = 1;
    rd("rx_pop_with_push", 32'hC, 32'h10);
    rx_valid = 0;
    rd("status_no_rxdrop", 32'h10, 32'h0000_0008);
    rx_push(8'h77);
    rd("status_rxdrop", 32'h10, 32'h0000_4008);
    rd("status_rxdrop_clr", 32'h10, 32'h0000_0008);
    for (int i = 1; i < 8; i++) rd("rx_drain", 32'hC, 32'(8'h10 + i));
    rd("rx_drain_99", 32'hC, 32'h99);

    rd("txspace_pre", 32'h0, 1);
    req_addr  = BASE + 32'h8;
    req_wdata = 8'h5A;
    req_we    = 1;
    req_re    = 1;
    cyc();
    req_we    = 0;
    req_re    = 0;
    check("we_re_hold", rdata, 1);
    wr(32'h0, 8'hFF);
    wr(32'h20, 8'hEE);
    wr(32'hC, 8'h11);
    rd("unmapped_rd", 32'h20, 0);
    rd("status_tx1", 32'h10, 32'h0000_0010);

    for (int i = 0; i < 8; i++) rx_push(8'(8'h20 + i));
    rx_data  = 8'hEE;
    rx_valid = 1;
    rd("status_drop_and_clr", 32'h10, 32'h0000_0018);
    rx_valid = 0;
    rd("status_flag_kept", 32'h10, 32'h0000_4018);
    rd("status_flag_clr", 32'h10, 32'h0000_0018);

    for (int i = 0; i < 4; i++) rd("rx_half", 32'hC, 32'(8'h20 + i));
    for (int i = 0; i < 3; i++) wr(32'h8, 8'(8'hC0 + i));
    rd("status_half", 32'h10, 32'h0000_0044);
    tx_ready = 1;
    cyc();
    #3;
    reset_n = 0;
    #1;
    check("arst_tx_valid", {31'b0, tx_valid}, 0);
    check("arst_tx_data", {24'b0, tx_data}, 0);
    check("arst_rdata", rdata, 0);
    check("arst_rx_ready", {31'b0, rx_ready}, 1);
    tx_ready = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    cyc();
    rd("post_rst_status", 32'h10, 0);
    rd("post_rst_txspace", 32'h0, 1);
    rd("post_rst_rxavail", 32'h4, 0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_mmio_responder.md
# uart_mmio_responder

Memory-mapped responder for the CPU's UART I/O window. Decodes single-cycle load/store requests from the MIPS150 datapath, buffers outgoing bytes in a TX FIFO feeding the UART transmitter, and buffers incoming bytes from the UART receiver in an RX FIFO. The CPU reads status, data and sticky error flags with a fixed one-cycle read latency and never stalls.

## Interface
- `BASE`, default 32'h8000_0000: base of the register window.
- `DEPTH`, default 8: entries per FIFO; must be a power of two, at least 2.
- `clk` in 1: sole clock; everything is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_addr` in 32: full byte address of the CPU access.
- `req_we` in 1: store strobe, one cycle per store.
- `req_re` in 1: load strobe, one cycle per load.
- `req_wdata` in 8: store data, byte lane 0.
- `rdata` out 32: registered load data.
- `tx_data` out 8: byte to the UART transmitter.
- `tx_valid` out 1: TX FIFO is non-empty.
- `tx_ready` in 1: transmitter accepts a byte this cycle.
- `rx_data` in 8: byte from the UART receiver.
- `rx_valid` in 1: receiver presents a byte this cycle; this is a single-cycle pulse per byte.
- `rx_ready` out 1: tied to 1; the block always accepts and drops the byte on overflow.

## Operation
- Register map, decoded by exact 32-bit compare against `BASE` plus offset:
  - +0x0, read: `{31'b0, tx_space}`, where `tx_space` = TX count < DEPTH.
  - +0x4, read: `{31'b0, rx_avail}`, where `rx_avail` = RX count != 0.
  - +0x8, write: push `req_wdata` into the TX FIFO.
  - +0xC, read: `{24'b0, RX head}`, and pops the RX FIFO.
  - +0x10, read: `{16'b0, tx_drop, rx_drop, 6'b0, tx_count[3:0], rx_count[3:0]}`. Reading this register clears both sticky flags.
- Request rules:
  - `req_we` and `req_re` both high: the write is performed and the read is ignored; `rdata` holds its value.
  - Unmapped read: `rdata` = 0.
  - Unmapped write, or a write to a read-only offset: ignored.
  - Write to a mapped offset other than +0x8: ignored.
- TX FIFO:
  - A push is accepted if not full, or if full and a pop (`tx_valid && tx_ready`) occurs in the same cycle.
  - Otherwise the byte is dropped and `tx_drop` is set.
  - `tx_data` = head entry, valid only while `tx_valid` is high.
- RX FIFO:
  - `rx_valid` pushes `rx_data`.
  - If the FIFO is full and no CPU pop occurs in the same cycle, the byte is dropped and `rx_drop` is set.
  - Reading +0xC with the FIFO empty returns 0 and pops nothing.
- Sticky flags: if a drop and the clearing read of +0x10 happen in the same cycle, the flag stays set. The read returns the pre-clear value.
- Counts saturate at DEPTH. Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is a separate log2(DEPTH)+1-bit register.

## Timing
- Reset values (asynchronous):
  - `rdata` = 0, `tx_valid` = 0, `tx_data` = 0.
  - Both FIFOs empty, both sticky flags 0, `rx_ready` = 1.
- Read latency: exactly 1 cycle. `rdata` updates on the edge ending the `req_re` cycle and holds until the next read.
- Status reads reflect state before any push or pop in the same cycle.
- TX path:
  - A byte stored in cycle N raises `tx_valid` at cycle N+1 when the FIFO was empty.
  - A handshake in cycle N exposes the next entry at N+1.
- RX path: a byte arriving with `rx_valid` in cycle N is visible to a +0x4 read issued at cycle N+1.
- Reset asserted mid-operation: all FIFO contents and flags are discarded immediately. `tx_valid` drops asynchronously.

## Structure
- Package `uart_mmio_pkg` holds:
  - Register offsets: `OFS_TXSPACE`, `OFS_RXAVAIL`, `OFS_TXDATA`, `OFS_RXDATA`, `OFS_STATUS`.
  - Status bit positions.
- Sub-module `byte_fifo` (parameters WIDTH, DEPTH) has ports push, pop, din, dout, count, full, empty. Push-when-full-with-pop is legal. It is instantiated once for TX and once for RX.
- The top level contains the address decode, the `rdata` register and the sticky flags.

## Test plan
- Reset, then read +0x0 and +0x4: `rdata` = 1, then 0; `tx_valid` = 0.
- Store 0x41, 0x42 to +0x8 with `tx_ready` = 0:
  - `tx_valid` = 1 and `tx_data` = 0x41.
  - Raise `tx_ready` for one cycle: `tx_data` = 0x42 on the next cycle.
- With `tx_ready` = 0, store 9 bytes (DEPTH = 8):
  - The 9th byte is dropped.
  - First +0x10 read = 0x0000_8080; second +0x10 read = 0x0000_0080.
- Pulse `rx_valid` with 0x55 and then 0xAA:
  - +0x4 = 1.
  - +0xC returns 0x55, then 0xAA.
  - A third +0xC read returns 0; +0x4 = 0.
- Fill the RX FIFO to 8 entries:
  - `rx_valid` together with a +0xC read: the new byte is accepted and `rx_drop` stays 0.
  - `rx_valid` alone while full: `rx_drop` = 1.
- Assert `reset_n` low mid-transfer with both FIFOs half full: all outputs return to reset values within the reset cycle, and subsequent status reads show zero counts.
